// File: rtl/spi_frame_reader.sv
// spi_frame_reader: mode-0 SPI master that sends an 8-bit command byte and then
// captures DATA_BITS of MISO data, presenting the frame with a one-cycle strobe.
module spi_frame_reader #(
    parameter int unsigned CLK_DIV   = 3,
    parameter int unsigned DATA_BITS = 48,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_IDLE   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           cmd,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 spi_cs,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
);

    localparam int unsigned NBITS    = 8 + DATA_BITS;
    localparam int unsigned CNT_MAX  = (CS_SETUP > CS_HOLD)
                                       ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                       : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W    = $clog2(NBITS + 1);
    // GAP ends one cycle early so a start issued on the first idle cycle
    // leaves spi_cs high for exactly CS_IDLE cycles.
    localparam int unsigned GAP_LAST = (CS_IDLE > 1) ? CS_IDLE - 2 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [DATA_BITS-1:0] cap_q, cap_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 miso_s1_q, miso_s2_q;

    // Two-flop synchronizer for the asynchronous MISO line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            cmd_q      <= '0;
            cap_q      <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            cmd_q      <= cmd_d;
            cap_q      <= cap_d;
            rx_data_q  <= rx_data_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Frame sequencing: next state and next register values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        cmd_d      = cmd_q;
        cap_d      = cap_q;
        rx_data_d  = rx_data_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_d   = {cmd[6:0], 1'b0};
                    mosi_d  = cmd[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: command-phase bits fall off the top.
                        cap_d = DATA_BITS'({cap_q, miso_s2_q});
                    end else if (bit_q == BIT_W'(NBITS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        mosi_d = cmd_q[7];
                        cmd_d  = {cmd_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cs_d       = 1'b1;
                    rx_data_d  = cap_q;
                    rx_valid_d = 1'b1;
                    mosi_d     = 1'b0;
                    cnt_d      = '0;
                    if (CS_IDLE == 1) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign spi_clk  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs   = cs_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule
